// File: rtl/pipe_stage_buf_pkg.sv
// Shared definitions for every pipeline-stage buffer instance.
package pipe_stage_buf_pkg;

    // Stage occupancy states.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } stage_state_e;

    // Standard stage payload widths so all four boundaries agree.
    localparam int unsigned NB_IFID_CTRL  = 8;
    localparam int unsigned NB_IFID_DATA  = 64;
    localparam int unsigned NB_IDEX_CTRL  = 8;
    localparam int unsigned NB_IDEX_DATA  = 136;
    localparam int unsigned NB_EXMEM_CTRL = 8;
    localparam int unsigned NB_EXMEM_DATA = 136;
    localparam int unsigned NB_MEMWB_CTRL = 8;
    localparam int unsigned NB_MEMWB_DATA = 72;

    localparam int unsigned NB_OCC = 2;

endpackage

// File: rtl/pipe_stage_buf_slot.sv
// One storage slot (valid, ctrl, data) with load/clear/hold, updated on the falling edge.
module pipe_stage_buf_slot #(
    parameter int unsigned         NB_CTRL  = 8,
    parameter int unsigned         NB_DATA  = 136,
    parameter logic [NB_CTRL-1:0]  CTRL_RST = '0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               load_i,
    input  logic               clear_i,
    input  logic [NB_CTRL-1:0] ctrl_i,
    input  logic [NB_DATA-1:0] data_i,
    output logic               valid_o,
    output logic [NB_CTRL-1:0] ctrl_o,
    output logic [NB_DATA-1:0] data_o
);

    logic               valid_q;
    logic [NB_CTRL-1:0] ctrl_q;
    logic [NB_DATA-1:0] data_q;

    // Clear drops the entry but keeps its payload; load captures a new entry.
    always_ff @(negedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            ctrl_q  <= CTRL_RST;
            data_q  <= '0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            ctrl_q  <= ctrl_i;
            data_q  <= data_i;
        end
    end

    assign valid_o = valid_q;
    assign ctrl_o  = ctrl_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Pipeline-stage register with valid/ready handshake, optional skid slot,
// freeze, flush-to-bubble and a saturating bubble counter.
module pipe_stage_buf
    import pipe_stage_buf_pkg::*;
#(
    parameter int unsigned         NB_CTRL     = 8,
    parameter int unsigned         NB_DATA     = 136,
    parameter logic [NB_CTRL-1:0]  CTRL_BUBBLE = '0,
    parameter int unsigned         SKID        = 1,
    parameter int unsigned         NB_CNT      = 16
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_pipeline_enable,
    input  logic               i_flush,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [NB_CTRL-1:0] i_ctrl,
    input  logic [NB_DATA-1:0] i_data,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [NB_CTRL-1:0] o_ctrl,
    output logic [NB_DATA-1:0] o_data,
    output logic [NB_OCC-1:0]  o_occupancy,
    output logic [NB_CNT-1:0]  o_bubble_cnt
);

    localparam logic [NB_CNT-1:0] CNT_MAX = {NB_CNT{1'b1}};

    stage_state_e       state_q, state_d;
    logic               en, in_fire, out_fire, flush_en;
    logic               main_load, main_clear, main_from_skid;
    logic               skid_load, skid_clear;
    logic               main_valid, skid_valid;
    logic [NB_CTRL-1:0] main_ctrl, skid_ctrl, main_ctrl_d;
    logic [NB_DATA-1:0] main_data, skid_data, main_data_d;
    logic [NB_CNT-1:0]  cnt_q, cnt_d;

    assign en       = i_pipeline_enable;
    assign flush_en = en & i_flush;
    assign in_fire  = en & i_valid & o_ready;
    assign out_fire = en & main_valid & i_ready;

    // Ready: from state only with a skid slot, otherwise passes downstream ready through.
    always_comb begin
        if (SKID != 0) o_ready = en & ~skid_valid;
        else           o_ready = en & (~main_valid | i_ready);
    end

    // State register.
    always_ff @(negedge i_clock) begin
        if (i_reset) state_q <= ST_EMPTY;
        else         state_q <= state_d;
    end

    // Next-state and slot control; flush overrides every transition.
    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_clear     = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        if (flush_en) begin
            state_d    = ST_EMPTY;
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d   = ST_FULL;
                        main_load = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (in_fire && out_fire) begin
                        main_load = 1'b1;
                    end else if (in_fire && (SKID != 0)) begin
                        state_d   = ST_SKID;
                        skid_load = 1'b1;
                    end else if (out_fire) begin
                        state_d    = ST_EMPTY;
                        main_clear = 1'b1;
                    end
                end
                ST_SKID: begin
                    if (out_fire) begin
                        state_d        = ST_FULL;
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clear     = 1'b1;
                    end
                end
                default: begin
                    state_d    = ST_EMPTY;
                    main_clear = 1'b1;
                    skid_clear = 1'b1;
                end
            endcase
        end
    end

    assign main_ctrl_d = main_from_skid ? skid_ctrl : i_ctrl;
    assign main_data_d = main_from_skid ? skid_data : i_data;

    pipe_stage_buf_slot #(
        .NB_CTRL  (NB_CTRL),
        .NB_DATA  (NB_DATA),
        .CTRL_RST (CTRL_BUBBLE)
    ) u_main_slot (
        .clk_i   (i_clock),
        .rst_i   (i_reset),
        .load_i  (main_load),
        .clear_i (main_clear),
        .ctrl_i  (main_ctrl_d),
        .data_i  (main_data_d),
        .valid_o (main_valid),
        .ctrl_o  (main_ctrl),
        .data_o  (main_data)
    );

    generate
        if (SKID != 0) begin : g_skid
            pipe_stage_buf_slot #(
                .NB_CTRL  (NB_CTRL),
                .NB_DATA  (NB_DATA),
                .CTRL_RST (CTRL_BUBBLE)
            ) u_skid_slot (
                .clk_i   (i_clock),
                .rst_i   (i_reset),
                .load_i  (skid_load),
                .clear_i (skid_clear),
                .ctrl_i  (i_ctrl),
                .data_i  (i_data),
                .valid_o (skid_valid),
                .ctrl_o  (skid_ctrl),
                .data_o  (skid_data)
            );
        end else begin : g_no_skid
            assign skid_valid = 1'b0;
            assign skid_ctrl  = '0;
            assign skid_data  = '0;
        end
    endgenerate

    // Bubble counter: counts enabled cycles with no valid head, saturating.
    always_comb begin
        cnt_d = cnt_q;
        if (en && !main_valid && (cnt_q != CNT_MAX)) cnt_d = cnt_q + NB_CNT'(1);
    end

    always_ff @(negedge i_clock) begin
        if (i_reset) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign o_valid      = main_valid;
    assign o_ctrl       = main_valid ? main_ctrl : CTRL_BUBBLE;
    assign o_data       = main_data;
    assign o_occupancy  = NB_OCC'(main_valid) + NB_OCC'(skid_valid);
    assign o_bubble_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench: a skid-buffered default instance driven by a vector table,
// plus a SKID=0, NB_CNT=4 instance for pass-through ready and saturation.
module tb_pipe_stage_buf;

    logic         clk = 1'b0;
    logic         rst, en, vld, rdy, fl;
    logic [7:0]   ctrl;
    logic [135:0] data;

    logic         a_ready, a_valid;
    logic [7:0]   a_ctrl;
    logic [135:0] a_data;
    logic [1:0]   a_occ;
    logic [15:0]  a_cnt;

    logic         b_ready, b_valid;
    logic [7:0]   b_ctrl;
    logic [135:0] b_data;
    logic [1:0]   b_occ;
    logic [3:0]   b_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_stage_buf dut_a (
        .i_clock(clk), .i_reset(rst), .i_pipeline_enable(en), .i_flush(fl),
        .i_valid(vld), .o_ready(a_ready), .i_ctrl(ctrl), .i_data(data),
        .o_valid(a_valid), .i_ready(rdy), .o_ctrl(a_ctrl), .o_data(a_data),
        .o_occupancy(a_occ), .o_bubble_cnt(a_cnt)
    );

    pipe_stage_buf #(.SKID(0), .NB_CNT(4)) dut_b (
        .i_clock(clk), .i_reset(rst), .i_pipeline_enable(en), .i_flush(fl),
        .i_valid(vld), .o_ready(b_ready), .i_ctrl(ctrl), .i_data(data),
        .o_valid(b_valid), .i_ready(rdy), .o_ctrl(b_ctrl), .o_data(b_data),
        .o_occupancy(b_occ), .o_bubble_cnt(b_cnt)
    );

    typedef struct {
        logic        rst, en, vld, rdy, fl;
        logic [7:0]  ctrl;
        logic [15:0] data;
        logic        ev;
        logic [7:0]  ectrl;
        logic [15:0] edata;
        logic [1:0]  eocc;
        logic        erdy;
        logic [15:0] ecnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic e, logic v, logic y, logic f,
                                logic [7:0] c, logic [15:0] d,
                                logic ev, logic [7:0] ec, logic [15:0] ed,
                                logic [1:0] eo, logic er, logic [15:0] en_cnt);
        vec_t t;
        t.rst = r; t.en = e; t.vld = v; t.rdy = y; t.fl = f; t.ctrl = c; t.data = d;
        t.ev = ev; t.ectrl = ec; t.edata = ed; t.eocc = eo; t.erdy = er; t.ecnt = en_cnt;
        return t;
    endfunction

    task automatic chk(input string name, input logic [135:0] act, input logic [135:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs applied at the falling (active) edge; outputs sampled just after the rising edge.
    task automatic tick();
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic e, input logic v, input logic y,
                         input logic f, input logic [7:0] c, input logic [15:0] d);
        rst = r; en = e; vld = v; rdy = y; fl = f; ctrl = c; data = 136'(d);
    endtask

    initial begin
        // reset, idle bubbles
        vecs.push_back(mk(1,1,0,0,0,8'h00,16'h0,  0,8'h00,16'h0, 2'd0,1,16'd0));
        vecs.push_back(mk(1,1,0,0,0,8'h00,16'h0,  0,8'h00,16'h0, 2'd0,1,16'd0));
        vecs.push_back(mk(0,1,0,0,0,8'h00,16'h0,  0,8'h00,16'h0, 2'd0,1,16'd1));
        vecs.push_back(mk(0,1,0,0,0,8'h00,16'h0,  0,8'h00,16'h0, 2'd0,1,16'd2));
        // streaming 1..10 with downstream always ready
        for (int k = 1; k <= 10; k++)
            vecs.push_back(mk(0,1,1,1,0,8'hA5,16'(k), 1,8'hA5,16'(k), 2'd1,1,16'd3));
        vecs.push_back(mk(0,1,0,1,0,8'h00,16'h0,  0,8'h00,16'd10,2'd0,1,16'd3));
        // fill skid with 1,2 while blocked, then drain in order
        vecs.push_back(mk(0,1,1,0,0,8'h3C,16'd1,  1,8'h3C,16'd1, 2'd1,1,16'd4));
        vecs.push_back(mk(0,1,1,0,0,8'h3C,16'd2,  1,8'h3C,16'd1, 2'd2,0,16'd4));
        vecs.push_back(mk(0,1,1,0,0,8'h3C,16'd3,  1,8'h3C,16'd1, 2'd2,0,16'd4));
        vecs.push_back(mk(0,1,0,1,0,8'h00,16'h0,  1,8'h3C,16'd2, 2'd1,1,16'd4));
        vecs.push_back(mk(0,1,0,1,0,8'h00,16'h0,  0,8'h00,16'd2, 2'd0,1,16'd4));
        // flush from a full skid with an incoming entry
        vecs.push_back(mk(0,1,1,0,0,8'h3C,16'h11, 1,8'h3C,16'h11,2'd1,1,16'd5));
        vecs.push_back(mk(0,1,1,0,0,8'h3C,16'h22, 1,8'h3C,16'h11,2'd2,0,16'd5));
        vecs.push_back(mk(0,1,1,0,1,8'h3C,16'h33, 0,8'h00,16'h11,2'd0,1,16'd5));
        vecs.push_back(mk(0,1,0,0,0,8'h00,16'h0,  0,8'h00,16'h11,2'd0,1,16'd6));
        // freeze with everything asserted
        vecs.push_back(mk(0,1,1,0,0,8'h3C,16'h44, 1,8'h3C,16'h44,2'd1,1,16'd7));
        for (int k = 0; k < 5; k++)
            vecs.push_back(mk(0,0,1,1,1,8'h3C,16'h55, 1,8'h3C,16'h44,2'd1,0,16'd7));
        vecs.push_back(mk(0,1,0,1,0,8'h00,16'h0,  0,8'h00,16'h44,2'd0,1,16'd7));

        drive(1,1,0,0,0,8'h00,16'h0);
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].vld, vecs[i].rdy, vecs[i].fl,
                  vecs[i].ctrl, vecs[i].data);
            tick();
            chk($sformatf("v%0d o_valid", i),     136'(a_valid), 136'(vecs[i].ev));
            chk($sformatf("v%0d o_ctrl", i),      136'(a_ctrl),  136'(vecs[i].ectrl));
            chk($sformatf("v%0d o_data", i),      a_data,        136'(vecs[i].edata));
            chk($sformatf("v%0d o_occupancy", i), 136'(a_occ),   136'(vecs[i].eocc));
            chk($sformatf("v%0d o_ready", i),     136'(a_ready), 136'(vecs[i].erdy));
            chk($sformatf("v%0d o_bubble_cnt", i),136'(a_cnt),   136'(vecs[i].ecnt));
        end

        // reset while two entries are held drops both
        drive(0,1,1,0,0,8'h3C,16'h77); tick();
        drive(0,1,1,0,0,8'h3C,16'h88); tick();
        chk("pre-reset occupancy", 136'(a_occ), 136'(2));
        drive(1,1,0,0,0,8'h00,16'h0); tick();
        chk("skid reset occupancy", 136'(a_occ),   136'(0));
        chk("skid reset o_valid",   136'(a_valid), 136'(0));
        chk("skid reset o_ctrl",    136'(a_ctrl),  136'(0));
        chk("skid reset o_data",    a_data,        136'(0));
        chk("skid reset o_ready",   136'(a_ready), 136'(1));
        chk("skid reset cnt",       136'(a_cnt),   136'(0));

        // 4-bit counter saturates at 4'hF
        drive(0,1,0,0,0,8'h00,16'h0);
        for (int k = 1; k <= 20; k++) begin
            tick();
            chk($sformatf("sat cnt k=%0d", k), 136'(b_cnt), 136'((k > 15) ? 15 : k));
        end
        chk("wide cnt after 20", 136'(a_cnt), 136'(20));
        drive(1,1,0,0,0,8'h00,16'h0); tick();
        chk("sat cnt reset", 136'(b_cnt), 136'(0));

        // SKID=0: ready follows downstream ready combinationally when full
        drive(0,1,1,0,0,8'h3C,16'h99); tick();
        chk("noskid o_valid",    136'(b_valid), 136'(1));
        chk("noskid data",       b_data,        136'(16'h99));
        chk("noskid ready blk",  136'(b_ready), 136'(0));
        vld = 1'b0; rdy = 1'b1; #1;
        chk("noskid ready pass", 136'(b_ready), 136'(1));
        tick();
        chk("noskid drained",    136'(b_valid), 136'(0));
        chk("noskid bubble ctrl",136'(b_ctrl),  136'(0));
        en = 1'b0; #1;
        chk("noskid ready frz",  136'(b_ready), 136'(0));
        chk("skid ready frz",    136'(a_ready), 136'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
